// File: rtl/fifo_control.sv
// fifo_control: single-clock frame buffer for the ping-pong RAM datapath.
// A burst of samples qualified by we_valid is captured into a 2**ADDR_W deep
// FIFO. The burst is then drained one word per rising edge of the read strobe.
// The read strobe rd_clk is treated as data and synchronized into clk.
// Each popped word appears on dout together with a one-cycle dout_valid pulse.
module fifo_control #(
    parameter int DATA_W    = 14,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_clk,
    input  logic              rd_clk,
    input  logic              we_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   fill_count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int FRAME_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     fill_r;
    logic [ADDR_W:0]     fill_nxt_s;
    logic                full_r;
    logic                empty_r;
    logic                overflow_r;
    logic [DATA_W-1:0]   dout_r;
    logic                dout_valid_r;
    logic [FRAME_W-1:0]  frame_cnt_r;

    logic                rd_s1_r;
    logic                rd_s2_r;
    logic                rd_s3_r;
    logic                rd_tick_s;

    logic                wr_en_s;
    logic                pop_s;
    logic                drop_s;
    logic                frame_last_s;
    logic                last_pop_s;

    // wr_clk exists only for pin compatibility; everything runs on clk.
    logic                unused_wr_clk_s;
    assign unused_wr_clk_s = wr_clk;

    // One tick per rising edge of the synchronized read strobe.
    assign rd_tick_s    = rd_s2_r & ~rd_s3_r;
    // The word being written this cycle is the last word of the frame.
    assign frame_last_s = (frame_cnt_r == FRAME_W'(FRAME_LEN - 1));
    // This pop drains the final stored word.
    assign last_pop_s   = pop_s && (fill_r == {{ADDR_W{1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode for the capture / drain sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (we_valid) begin
                    state_nxt_s = frame_last_s ? ST_READ : ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!we_valid || frame_last_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (empty_r || last_pop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes: write, pop, and discard of incoming words.
    always_comb begin
        wr_en_s = 1'b0;
        pop_s   = 1'b0;
        drop_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_WRITE: begin
                if (we_valid) begin
                    wr_en_s = ~full_r;
                    drop_s  = full_r;
                end else begin
                    wr_en_s = 1'b0;
                    drop_s  = 1'b0;
                end
            end
            ST_READ: begin
                pop_s  = rd_tick_s & ~empty_r;
                drop_s = we_valid;
            end
            default: begin
                wr_en_s = 1'b0;
                pop_s   = 1'b0;
                drop_s  = 1'b0;
            end
        endcase
    end

    // Occupancy after this cycle's write and/or pop.
    always_comb begin
        fill_nxt_s = fill_r;
        case ({wr_en_s, pop_s})
            2'b10:   fill_nxt_s = fill_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   fill_nxt_s = fill_r - {{ADDR_W{1'b0}}, 1'b1};
            default: fill_nxt_s = fill_r;
        endcase
    end

    // Two-flop synchronizer plus edge-detect delay flop for the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_r <= 1'b0;
            rd_s2_r <= 1'b0;
            rd_s3_r <= 1'b0;
        end else begin
            rd_s1_r <= rd_clk;
            rd_s2_r <= rd_s1_r;
            rd_s3_r <= rd_s2_r;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy flags, frame position and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {ADDR_W{1'b0}};
            rd_ptr_r    <= {ADDR_W{1'b0}};
            fill_r      <= {(ADDR_W + 1){1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            fill_r  <= fill_nxt_s;
            full_r  <= (fill_nxt_s == (ADDR_W + 1)'(DEPTH));
            empty_r <= (fill_nxt_s == {(ADDR_W + 1){1'b0}});
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            // The frame position advances on every qualified word, including
            // dropped ones, so that a frame always terminates.
            if ((state_r == ST_IDLE) && we_valid) begin
                frame_cnt_r <= {{(FRAME_W - 1){1'b0}}, 1'b1};
            end else if ((state_r == ST_WRITE) && we_valid) begin
                frame_cnt_r <= frame_cnt_r + {{(FRAME_W - 1){1'b0}}, 1'b1};
            end else if (state_r != ST_WRITE) begin
                frame_cnt_r <= {FRAME_W{1'b0}};
            end
        end
    end

    // Registered read port: dout holds between pops, dout_valid pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= pop_s;
            if (pop_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign state      = state_r;
    assign fill_count = fill_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_fifo_control.sv
// Directed self-checking bench for fifo_control.
module tb_fifo_control;

    logic        clk;
    logic        rst_n;
    logic        rd_clk;
    logic        we_valid;
    logic [13:0] data_in;
    logic [13:0] dout;
    logic        dout_valid;
    logic [1:0]  state;
    logic [10:0] fill_count;
    logic        full;
    logic        empty;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    fifo_control #(.DATA_W(14), .ADDR_W(10), .FRAME_LEN(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_clk     (clk),
        .rd_clk     (rd_clk),
        .we_valid   (we_valid),
        .data_in    (data_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .state      (state),
        .fill_count (fill_count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive n consecutive words base..base+n-1; return 1ns after the last write edge.
    task automatic write_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            we_valid = 1'b1;
            data_in  = 14'(base + i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(negedge clk);
        we_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One 10 ns read strobe; expects dout_valid on the 3rd edge with the given word.
    task automatic read_word(input logic [13:0] exp);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        @(negedge clk);
        rd_clk = 1'b1;
        for (int j = 1; j <= 8 && !seen; j++) begin
            @(posedge clk);
            #1;
            if (dout_valid === 1'b1) begin
                seen = 1'b1;
                k    = j;
            end
            if (j == 1) begin
                @(negedge clk);
                rd_clk = 1'b0;
            end
        end
        rd_clk = 1'b0;
        chk("rd_latency", k, 3);
        chk("dout", dout, exp);
        @(posedge clk);
        #1;
        chk("dv_single", dout_valid, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    // Hold rd_clk high for 50 cycles; exactly one word must come out.
    task automatic hold_read(input logic [13:0] exp);
        int          cnt;
        logic [13:0] got;
        cnt = 0;
        got = 14'h0;
        @(negedge clk);
        rd_clk = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (dout_valid === 1'b1) begin
                cnt++;
                got = dout;
            end
        end
        @(negedge clk);
        rd_clk = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (dout_valid === 1'b1) cnt++;
        end
        chk("hold_count", cnt, 1);
        chk("hold_dout", got, exp);
    endtask

    task automatic full_frame(input string tag);
        write_frame(0, 1024);
        chk({tag, "_state"}, state, 2'd2);
        chk({tag, "_full"}, full, 1'b1);
        chk({tag, "_fill"}, fill_count, 11'd1024);
        chk({tag, "_empty"}, empty, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        end_frame();
        for (int i = 0; i < 1024; i++) read_word(14'(i));
        chk({tag, "_end_state"}, state, 2'd0);
        chk({tag, "_end_empty"}, empty, 1'b1);
        chk({tag, "_end_full"}, full, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_clk   = 1'b0;
        we_valid = 1'b0;
        data_in  = 14'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_dout", dout, 14'd0);
        chk("rst_dv", dout_valid, 1'b0);
        chk("rst_fill", fill_count, 11'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame from pointer 0.
        full_frame("fullA");

        // Short frame 100..109.
        write_frame(100, 10);
        chk("short_state_w", state, 2'd1);
        chk("short_fill", fill_count, 11'd10);
        end_frame();
        chk("short_state_r", state, 2'd2);
        for (int i = 0; i < 10; i++) read_word(14'(100 + i));
        chk("short_end_state", state, 2'd0);
        chk("short_end_empty", empty, 1'b1);

        // Full frame starting at pointer 10: pointers wrap inside the frame.
        full_frame("fullB");

        // Overflow during READ plus held read strobe.
        write_frame(300, 6);
        end_frame();
        read_word(14'd300);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_valid = 1'b1;
            data_in  = 14'h3fff;
        end
        @(negedge clk);
        we_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_fill", fill_count, 11'd5);
        chk("ovf_state", state, 2'd2);
        read_word(14'd301);
        hold_read(14'd302);
        read_word(14'd303);
        read_word(14'd304);
        chk("ovf_sticky", overflow, 1'b1);
        read_word(14'd305);
        chk("ovf_end_state", state, 2'd0);
        chk("ovf_end_empty", empty, 1'b1);
        chk("ovf_sticky_idle", overflow, 1'b1);

        // Reset in the middle of a READ with 500 words remaining.
        write_frame(0, 1024);
        end_frame();
        for (int i = 0; i < 524; i++) read_word(14'(i));
        chk("mid_fill", fill_count, 11'd500);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 2'd0);
        chk("mid_rst_fill", fill_count, 11'd0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_dv", dout_valid, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        write_frame(200, 5);
        end_frame();
        chk("post_rst_state", state, 2'd2);
        for (int i = 0; i < 5; i++) read_word(14'(200 + i));
        chk("post_rst_end_state", state, 2'd0);
        chk("post_rst_ovf", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
